// File: rtl/program_executor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// program_executor: runs an 18-bit program on an 8 x 8-bit register file, one
// instruction per FETCH/EXEC pair, started by the execute button. Rev 1.0
// ----------------------------------------------------------------------------
module program_executor #(
  parameter int NUM_INSTR = 10,
  parameter int MAX_STEPS = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    exec_btn_n,
  input  logic [18*NUM_INSTR-1:0] instr_flat,
  input  logic [3:0]              instr_count,
  output logic [63:0]             regs_flat,
  output logic [3:0]              pc,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    zero_flag,
  output logic                    carry_flag,
  output logic [7:0]              disp_value
);

  localparam int                c_step_w    = $clog2(MAX_STEPS + 1);
  localparam logic [3:0]        c_num_instr = 4'(NUM_INSTR);
  localparam logic [c_step_w-1:0] c_max_steps = c_step_w'(MAX_STEPS);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR,
    OP_LDI, OP_ADDI, OP_MOV, OP_DISP, OP_JZ, OP_JMP, OP_NOP, OP_HALT
  } opcode_t;

  state_t                r_state;
  logic                  r_btn_meta;
  logic                  r_btn_sync;
  logic                  r_btn_prev;
  logic [17:0]           r_ir;
  logic [c_step_w-1:0]   r_step;
  logic [7:0]            r_regs [8];

  logic                  w_start;
  logic [3:0]            w_n;
  logic [17:0]           w_slot [16];
  opcode_t               w_op;
  logic [2:0]            w_id1;
  logic [2:0]            w_id2;
  logic [7:0]            w_imm;
  logic [7:0]            w_a;
  logic [7:0]            w_b;
  logic [8:0]            w_res;
  logic                  w_wr;
  logic                  w_upd_z;
  logic                  w_upd_c;
  logic                  w_disp;
  logic                  w_jump;
  logic                  w_halt;
  logic [4:0]            w_pc_inc;
  logic [3:0]            w_next_pc;
  logic                  w_bad_target;
  logic                  w_end;
  logic [c_step_w-1:0]   w_step_next;

  // Slots past NUM_INSTR read as zero so pc can index the array directly.
  for (genvar k = 0; k < 16; k++) begin : g_slot
    if (k < NUM_INSTR) begin : g_used
      assign w_slot[k] = instr_flat[18*k +: 18];
    end else begin : g_unused
      assign w_slot[k] = '0;
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_regs_flat
    assign regs_flat[8*k +: 8] = r_regs[k];
  end

  assign w_start     = r_btn_prev & ~r_btn_sync;
  assign w_n         = (instr_count > c_num_instr) ? c_num_instr : instr_count;
  assign w_op        = opcode_t'(r_ir[17:14]);
  assign w_id1       = r_ir[13:11];
  assign w_id2       = r_ir[10:8];
  assign w_imm       = r_ir[7:0];
  assign w_a         = r_regs[w_id1];
  assign w_b         = r_regs[w_id2];
  assign w_step_next = r_step + 1'b1;
  assign w_pc_inc    = {1'b0, pc} + 5'd1;

  always_comb begin
    w_res   = '0;
    w_wr    = 1'b0;
    w_upd_z = 1'b0;
    w_upd_c = 1'b0;
    w_disp  = 1'b0;
    w_jump  = 1'b0;
    w_halt  = 1'b0;
    case (w_op)
      OP_ADD:  begin w_res = {1'b0, w_a} + {1'b0, w_b}; w_upd_c = 1'b1; end
      // Bit 8 of the 9-bit difference is the borrow.
      OP_SUB:  begin w_res = {1'b0, w_a} - {1'b0, w_b}; w_upd_c = 1'b1; end
      OP_AND:  w_res = {1'b0, w_a & w_b};
      OP_OR:   w_res = {1'b0, w_a | w_b};
      OP_XOR:  w_res = {1'b0, w_a ^ w_b};
      OP_NOT:  w_res = {1'b0, ~w_b};
      OP_SHL:  begin w_res = {w_b, 1'b0}; w_upd_c = 1'b1; end
      OP_SHR:  w_res = {2'b00, w_b[7:1]};
      OP_LDI:  w_res = {1'b0, w_imm};
      OP_ADDI: begin w_res = {1'b0, w_a} + {1'b0, w_imm}; w_upd_c = 1'b1; end
      OP_MOV:  w_res = {1'b0, w_b};
      OP_DISP: w_disp = 1'b1;
      OP_JZ:   w_jump = zero_flag;
      OP_JMP:  w_jump = 1'b1;
      OP_NOP:  ;
      default: w_halt = 1'b1;
    endcase
    w_wr    = (r_ir[17:14] <= 4'hA);
    w_upd_z = w_wr;
  end

  assign w_next_pc    = w_jump ? w_imm[3:0] : w_pc_inc[3:0];
  assign w_bad_target = w_jump & (w_imm[3:0] >= w_n);
  assign w_end        = w_halt | (w_jump ? w_bad_target : (w_pc_inc >= {1'b0, w_n}));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_btn_meta <= 1'b1;
      r_btn_sync <= 1'b1;
      r_btn_prev <= 1'b1;
      r_ir       <= '0;
      r_step     <= '0;
      pc         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      disp_value <= '0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      r_btn_meta <= exec_btn_n;
      r_btn_sync <= r_btn_meta;
      r_btn_prev <= r_btn_sync;
      done       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            pc     <= '0;
            r_step <= '0;
            err    <= 1'b0;
            if (w_n == 4'd0) begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              busy    <= 1'b1;
              r_state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          r_ir    <= w_slot[pc];
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_wr) r_regs[w_id1] <= w_res[7:0];
          if (w_upd_z) zero_flag <= (w_res[7:0] == 8'd0);
          if (w_upd_c) carry_flag <= w_res[8];
          if (w_disp) disp_value <= w_a;
          pc     <= w_next_pc;
          r_step <= w_step_next;
          if (w_end) begin
            err     <= w_bad_target;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else if (w_step_next == c_max_steps) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
